// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences MIPS lb/lbu/lh/lhu/lw/sb/sh/sw onto a word-wide big-endian RAM.
// Optional `MEM_BOUNDS_CHECK_EN rejects accesses whose aligned word extends past MEM_BYTES-1.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 61
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_nRD,
  output logic        ram_nWR,
  input  logic [31:0] ram_rdata
);
  localparam logic [3:0] OpLb  = 4'b0000;
  localparam logic [3:0] OpLh  = 4'b0001;
  localparam logic [3:0] OpLw  = 4'b0011;
  localparam logic [3:0] OpLbu = 4'b0100;
  localparam logic [3:0] OpLhu = 4'b0101;
  localparam logic [3:0] OpSb  = 4'b1000;
  localparam logic [3:0] OpSh  = 4'b1001;
  localparam logic [3:0] OpSw  = 4'b1011;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif
  localparam logic [32:0] LastByte = 33'(MEM_BYTES - 32'd1);

  typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StWrite, StDone} state_e;

  state_e      r_state, w_state_next;
  logic [3:0]  r_op;
  logic [31:0] r_addr;
  logic [15:0] r_wdata;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept, w_legal, w_is_load, w_is_sw, w_misaligned, w_oob, w_req_err;
  logic [32:0] w_last_byte;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val, w_rmw_word;

  assign w_accept = (r_state == StIdle) && req;

  // Request decode and alignment check on the incoming (not yet latched) request.
  always_comb begin
    w_legal      = 1'b1;
    w_is_load    = 1'b0;
    w_is_sw      = 1'b0;
    w_misaligned = 1'b0;
    case (op)
      OpLb, OpLbu: w_is_load = 1'b1;
      OpLh, OpLhu: begin w_is_load = 1'b1; w_misaligned = addr[0];   end
      OpLw:        begin w_is_load = 1'b1; w_misaligned = |addr[1:0]; end
      OpSb:        w_misaligned = 1'b0;
      OpSh:        w_misaligned = addr[0];
      OpSw:        begin w_is_sw = 1'b1;   w_misaligned = |addr[1:0]; end
      default:     w_legal = 1'b0;
    endcase
  end

  assign w_last_byte = {1'b0, addr[31:2], 2'b00} + 33'd3;
  assign w_oob       = w_last_byte > LastByte;
  assign w_req_err   = !w_legal || w_misaligned || (BoundsEn && w_oob);

  // Big-endian lane select for loads: offset 0 is the most significant byte.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = ram_rdata[31:24];
      2'd1:    w_byte = ram_rdata[23:16];
      2'd2:    w_byte = ram_rdata[15:8];
      default: w_byte = ram_rdata[7:0];
    endcase
    w_half = r_addr[1] ? ram_rdata[15:0] : ram_rdata[31:16];
    case (r_op)
      OpLb:    w_load_val = {{24{w_byte[7]}}, w_byte};
      OpLbu:   w_load_val = {24'd0, w_byte};
      OpLh:    w_load_val = {{16{w_half[15]}}, w_half};
      OpLhu:   w_load_val = {16'd0, w_half};
      default: w_load_val = ram_rdata;
    endcase
  end

  always_comb begin
    w_rmw_word = ram_rdata;
    if (r_op == OpSh) begin
      if (r_addr[1]) w_rmw_word[15:0]  = r_wdata;
      else           w_rmw_word[31:16] = r_wdata;
    end else begin
      case (r_addr[1:0])
        2'd0:    w_rmw_word[31:24] = r_wdata[7:0];
        2'd1:    w_rmw_word[23:16] = r_wdata[7:0];
        2'd2:    w_rmw_word[15:8]  = r_wdata[7:0];
        default: w_rmw_word[7:0]   = r_wdata[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (req) begin
          if (w_req_err)      w_state_next = StDone;
          else if (w_is_load) w_state_next = StLoad;
          else if (w_is_sw)   w_state_next = StWrite;
          else                w_state_next = StRmwRd;
        end
      end
      StLoad:  w_state_next = StDone;
      StRmwRd: w_state_next = StWrite;
      StWrite: w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Write strobe is gated by rst so a reset landing in WRITE never commits to RAM.
  always_comb begin
    ready     = (r_state == StIdle);
    done      = (r_state == StDone);
    err       = (r_state == StDone) && r_err;
    ram_nRD   = (r_state == StLoad) || (r_state == StRmwRd);
    ram_nWR   = ~((r_state == StWrite) && !rst);
    ram_addr  = (r_state == StIdle) ? 32'd0 : {r_addr[31:2], 2'b00};
    ram_wdata = (r_state == StWrite) ? r_merge : 32'd0;
    rdata     = r_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 16'd0;
      r_merge <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= op;
        r_addr  <= addr;
        r_wdata <= wdata[15:0];
        r_err   <= w_req_err;
        r_merge <= wdata;
      end
      if (r_state == StLoad)  r_rdata <= w_load_val;
      if (r_state == StRmwRd) r_merge <= w_rmw_word;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array RAM, byte-level reference model, directed and random ops.
// Build with +define+MEM_BOUNDS_CHECK_EN to exercise the bounds-check variant.
module tb_mem_access_unit;
  localparam int MemBytes = 61;

  logic        clk = 1'b0;
  logic        rst, req;
  logic [3:0]  op;
  logic [31:0] addr, wdata;
  logic        ready, done, err;
  logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata;
  logic        ram_nRD, ram_nWR;

  mem_access_unit #(.MEM_BYTES(MemBytes)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .err(err), .rdata(rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_nRD(ram_nRD), .ram_nWR(ram_nWR),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem     [64];
  logic [7:0]  ref_mem [64];
  logic [31:0] ref_rdata;
  logic [31:0] last_wdata;
  logic [5:0]  ram_base;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [7:0] init_byte(input int i);
    logic [7:0] pre [12];
    pre = '{8'h80, 8'h12, 8'h34, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h44};
    if (i < 12 && (i < 4 || i >= 8)) return pre[i];
    return 8'(i * 37 + 5);
  endfunction

  // Behavioural RAM: combinational read, write on negedge while nWR is low.
  assign ram_base  = {ram_addr[5:2], 2'b00};
  assign ram_rdata = {mem[ram_base], mem[ram_base + 6'd1], mem[ram_base + 6'd2],
                      mem[ram_base + 6'd3]};
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = init_byte(i);
    forever begin
      @(negedge clk);
      if (ram_nWR === 1'b0) begin
        mem[ram_base]        = ram_wdata[31:24];
        mem[ram_base + 6'd1] = ram_wdata[23:16];
        mem[ram_base + 6'd2] = ram_wdata[15:8];
        mem[ram_base + 6'd3] = ram_wdata[7:0];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_mem(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(name, 32'(bad), 32'd0);
  endtask

  // Issues one request, predicts its outcome from byte-level rules, checks every cycle until IDLE.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] wd,
                       input bit hold, input logic [3:0] no, input logic [31:0] na,
                       output logic [31:0] got_rd, output int got_lat, output logic got_err,
                       output logic [31:0] got_raddr);
    bit          legal, is_ld, is_st, uns, e_err;
    int          sz, e_lat, ai, wi, nwr, nrd, e_nrd, e_nwr;
    logic [31:0] aligned, old_rd, new_rd, e_word;
    legal = 1'b1; is_ld = 1'b0; is_st = 1'b0; sz = 0;
    case (o)
      4'h0, 4'h4: begin is_ld = 1'b1; sz = 1; end
      4'h1, 4'h5: begin is_ld = 1'b1; sz = 2; end
      4'h3:       begin is_ld = 1'b1; sz = 4; end
      4'h8:       begin is_st = 1'b1; sz = 1; end
      4'h9:       begin is_st = 1'b1; sz = 2; end
      4'hB:       begin is_st = 1'b1; sz = 4; end
      default:    legal = 1'b0;
    endcase
    uns     = (o == 4'h4) || (o == 4'h5);
    aligned = {a[31:2], 2'b00};
    ai      = int'(a[5:0]);
    wi      = int'({a[5:2], 2'b00});
    e_err   = !legal || (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'd0);
`ifdef MEM_BOUNDS_CHECK_EN
    if (longint'(aligned) + 3 > longint'(MemBytes - 1)) e_err = 1'b1;
`endif
    e_lat  = e_err ? 1 : (is_ld || sz == 4) ? 2 : 3;
    e_nrd  = (!e_err && (is_ld || (is_st && sz < 4))) ? 1 : 0;
    e_nwr  = (!e_err && is_st) ? 1 : 0;
    old_rd = ref_rdata;
    new_rd = old_rd;
    if (!e_err && is_ld) begin
      if (sz == 1)
        new_rd = uns ? {24'd0, ref_mem[ai]} : {{24{ref_mem[ai][7]}}, ref_mem[ai]};
      else if (sz == 2)
        new_rd = uns ? {16'd0, ref_mem[ai], ref_mem[ai + 1]}
                     : {{16{ref_mem[ai][7]}}, ref_mem[ai], ref_mem[ai + 1]};
      else
        new_rd = {ref_mem[ai], ref_mem[ai + 1], ref_mem[ai + 2], ref_mem[ai + 3]};
    end
    if (!e_err && is_st) begin
      if (sz == 1) ref_mem[ai] = wd[7:0];
      else if (sz == 2) begin ref_mem[ai] = wd[15:8]; ref_mem[ai + 1] = wd[7:0]; end
      else begin
        ref_mem[ai] = wd[31:24]; ref_mem[ai + 1] = wd[23:16];
        ref_mem[ai + 2] = wd[15:8]; ref_mem[ai + 3] = wd[7:0];
      end
    end
    e_word    = {ref_mem[wi], ref_mem[wi + 1], ref_mem[wi + 2], ref_mem[wi + 3]};
    ref_rdata = new_rd;

    req = 1'b1; op = o; addr = a; wdata = wd;
    chk("ready_at_req", 32'(ready), 32'd1);
    @(posedge clk); #1;
    if (hold) begin op = no; addr = na; end
    else req = 1'b0;
    nwr = 0; nrd = 0; got_lat = 0; got_err = 1'b0; got_rd = 32'd0; got_raddr = ram_addr;
    for (int k = 1; k <= e_lat + 1; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      chk("ready", 32'(ready), 32'(k > e_lat));
      chk("done", 32'(done), 32'(k == e_lat));
      chk("ram_addr", ram_addr, (k <= e_lat) ? aligned : 32'd0);
      chk("rdata", rdata, (k >= e_lat) ? new_rd : old_rd);
      if (k == e_lat) chk("err", 32'(err), 32'(e_err));
      if (done === 1'b1 && got_lat == 0) begin
        got_lat = k; got_err = err; got_rd = rdata;
      end
      if (ram_nWR === 1'b0) begin nwr++; last_wdata = ram_wdata; end
      if (ram_nRD === 1'b1) nrd++;
    end
    chk("nwr_cycles", 32'(nwr), 32'(e_nwr));
    chk("nrd_cycles", 32'(nrd), 32'(e_nrd));
    if (e_nwr == 1) chk("ram_wdata", last_wdata, e_word);
    chk_mem("ram_contents");
  endtask

  logic [31:0] g_rd, g_ra;
  int          g_lat;
  logic        g_err;
  logic [3:0]  r_op;
  logic [31:0] r_addr;
  logic [3:0]  legal_ops [8];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    legal_ops = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hB};
    for (int i = 0; i < 64; i++) ref_mem[i] = init_byte(i);
    ref_rdata = 32'd0;
    last_wdata = 32'd0;
    rst = 1'b1; req = 1'b0; op = 4'd0; addr = 32'd0; wdata = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_nrd", 32'(ram_nRD), 32'd0);
    chk("rst_nwr", 32'(ram_nWR), 32'd1);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    rst = 1'b0;

    // Directed loads on bytes 80 12 34 F0.
    issue(4'h0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, g_rd, g_lat, g_err, g_ra);
    chk("lb0_rdata", g_rd, 32'hFFFFFF80);
    chk("lb0_lat", 32'(g_lat), 32'd2);
    issue(4'h4, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, g_rd, g_lat, g_err, g_ra);
    chk("lbu0_rdata", g_rd, 32'h00000080);
    issue(4'h1, 32'd2, 32'd0, 1'b0, 4'd0, 32'd0, g_rd, g_lat, g_err, g_ra);
    chk("lh2_rdata", g_rd, 32'h000034F0);
    issue(4'h3, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, g_rd, g_lat, g_err, g_ra);
    chk("lw0_rdata", g_rd, 32'h801234F0);

    // Sub-word store read-modify-write.
    issue(4'h8, 32'd9, 32'h000000AB, 1'b0, 4'd0, 32'd0, g_rd, g_lat, g_err, g_ra);
    chk("sb9_lat", 32'(g_lat), 32'd3);
    chk("sb9_word", last_wdata, 32'h11AB3344);
    issue(4'h3, 32'd8, 32'd0, 1'b0, 4'd0, 32'd0, g_rd, g_lat, g_err, g_ra);
    chk("lw8_rdata", g_rd, 32'h11AB3344);

    // Error responses.
    issue(4'h9, 32'd3, 32'h0000BEEF, 1'b0, 4'd0, 32'd0, g_rd, g_lat, g_err, g_ra);
    chk("sh3_lat", 32'(g_lat), 32'd1);
    chk("sh3_err", 32'(g_err), 32'd1);
    issue(4'h2, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, g_rd, g_lat, g_err, g_ra);
    chk("op2_err", 32'(g_err), 32'd1);
    chk("op2_rdata_kept", g_rd, 32'h11AB3344);

    // Back-to-back with req held high through the first transaction.
    issue(4'hB, 32'd4, 32'hDEADBEEF, 1'b1, 4'h3, 32'd4, g_rd, g_lat, g_err, g_ra);
    chk("sw4_lat", 32'(g_lat), 32'd2);
    issue(4'h3, 32'd4, 32'd0, 1'b0, 4'd0, 32'd0, g_rd, g_lat, g_err, g_ra);
    chk("lw4_rdata", g_rd, 32'hDEADBEEF);

    // Reset landing in the WRITE cycle of an SB.
    req = 1'b1; op = 4'h8; addr = 32'd8; wdata = 32'h00000077;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("rst_write_nwr", 32'(ram_nWR), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_write_ready", 32'(ready), 32'd1);
    chk("rst_write_done", 32'(done), 32'd0);
    chk("rst_write_rdata", rdata, 32'd0);
    chk_mem("rst_write_ram");
    ref_rdata = 32'd0;

`ifdef MEM_BOUNDS_CHECK_EN
    issue(4'h3, 32'd56, 32'd0, 1'b0, 4'd0, 32'd0, g_rd, g_lat, g_err, g_ra);
    chk("lw56_err", 32'(g_err), 32'd0);
    issue(4'h3, 32'd60, 32'd0, 1'b0, 4'd0, 32'd0, g_rd, g_lat, g_err, g_ra);
    chk("lw60_err", 32'(g_err), 32'd1);
`else
    issue(4'h3, 32'd60, 32'd0, 1'b0, 4'd0, 32'd0, g_rd, g_lat, g_err, g_ra);
    chk("lw60_ram_addr", g_ra, 32'd60);
    chk("lw60_err", 32'(g_err), 32'd0);
`endif

    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 3) == 0) r_op = 4'($urandom_range(0, 15));
      else r_op = legal_ops[$urandom_range(0, 7)];
      r_addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'd0;
      issue(r_op, r_addr, $urandom, 1'b0, 4'd0, 32'd0, g_rd, g_lat, g_err, g_ra);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer between the CPU datapath and the byte-addressed, big-endian 32-bit data RAM.
- Converts MIPS lb/lbu/lh/lhu/lw/sb/sh/sw requests into aligned word accesses on the RAM's nRD/nWR interface.
- Performs byte/halfword extraction with sign or zero extension on loads, and read-modify-write for sub-word stores, because the RAM only writes full words.
- Reports misalignment and illegal-op errors with a single done pulse.

Parameters:
- MEM_BYTES, 61, RAM size in bytes; used only by the optional bounds check.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request strobe; accepted only when ready=1.
- op  in  4  access type, equal to MIPS opcode[3:0]: 0000 LB, 0001 LH, 0011 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1011 SW; any other value is illegal.
- addr  in  32  byte address.
- wdata  in  32  store data; the byte or halfword is taken from the low bits.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = misaligned, illegal op or out of bounds; no RAM write occurred.
- rdata  out  32  load result, extended; holds until the next successful load completes.
- ram_addr  out  32  word-aligned address, {addr_q[31:2],2'b00}.
- ram_wdata  out  32  merged store word.
- ram_nRD  out  1  1 = RAM drives read data.
- ram_nWR  out  1  0 = RAM writes on the negedge of clk.
- ram_rdata  in  32  RAM read data, combinational.

Behaviour:
- Reset values: ready=1, done=0, err=0, rdata=0, ram_nRD=0, ram_nWR=1, ram_addr=0, ram_wdata=0. State returns to IDLE from any state. Reset has priority over req.
- ram_nWR = ~(state==WRITE && !rst), so no RAM write occurs in a cycle where rst=1, even mid-operation.
- States and transitions:
  - IDLE: on req, latch op, addr and wdata into op_q, addr_q and wdata_q.
    - Error (illegal op; LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) -> DONE with err_q=1.
    - Load -> LOAD.
    - SW -> WRITE, with merge word = wdata.
    - SB/SH -> RMW_RD.
  - LOAD: ram_nRD=1. Capture the extracted result into rdata at posedge, then go to DONE.
  - RMW_RD: ram_nRD=1. Capture ram_rdata, replace the target lane with wdata_q[7:0] or [15:0], then go to WRITE.
  - WRITE: ram_nWR=0 and ram_wdata=merge word for exactly one cycle, then go to DONE.
  - DONE: done=1 and err=err_q, then go to IDLE. err_q is cleared on the next accept.
- Lane map, big-endian:
  - Byte offset 0/1/2/3 -> bits [31:24]/[23:16]/[15:8]/[7:0].
  - Halfword offset 0/2 -> bits [31:16]/[15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Latency from the accept edge to done: error 1 cycle, load 2, SW 2, SB/SH 3. Minimum issue interval is latency+1.
- ram_addr holds the aligned address from the cycle after accept until the cycle after DONE. It is 0 in IDLE.
- req while ready=0, including the DONE cycle, is ignored and not queued.
- rdata is unchanged by stores and by errored requests.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- Defined: a request whose aligned address + 3 > MEM_BYTES-1 is errored like a misalignment (DONE with err=1, no RAM access). With the default MEM_BYTES, the highest legal aligned address is 56.
- Undefined: no range check; any address is passed to the RAM.

Test Plan:
- RAM bytes 0..3 = 80 12 34 F0; LB addr 0 -> done at accept+2, rdata=FFFFFF80; LBU addr 0 -> 00000080; LH addr 2 -> 000034F0; LW addr 0 -> 801234F0.
- RAM word 8 = 11223344; SB addr 9, wdata=000000AB -> nWR low exactly one cycle with ram_wdata=11AB3344; done at accept+3; LW addr 8 returns 11AB3344.
- SH addr 3 -> done at accept+1 with err=1, ram_nWR never 0, RAM unchanged; op=0010 -> same error response.
- SW addr 4, wdata=DEADBEEF, followed by req held high continuously -> second request accepted only when ready=1 after DONE; word 4 = DEADBEEF.
- SB issued, rst=1 asserted in the WRITE cycle -> ram_nWR stays 1, RAM unchanged; next cycle ready=1, done=0, rdata=0.
- With MEM_BOUNDS_CHECK_EN defined: LW addr 56 succeeds; LW addr 60 -> err=1. Without it, LW addr 60 issues ram_addr=60.
